mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register. It consumes the 71-bit EX/MEM bundle, performs word loads and stores against a local data memory, and registers the result into a 71-bit MEM/WB bundle for the write-back stage. It also keeps saturating load/store counters and a sticky misalignment fault for debug.

---
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word loads/stores against a local data array,
// registered MEM/WB bundle, saturating access counters and a sticky misalignment fault.
module mem_stage #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [70:0]       ex_mem_bundle_in,
  output logic [70:0]       mem_wb_bundle_out,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output logic              misaligned_fault,
  output logic [31:0]       fault_addr
);

  typedef struct packed {
    logic [1:0]  ctl;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
  } mem_wb_t;

  localparam logic [1:0] CTL_ALU   = 2'b01;
  localparam logic [1:0] CTL_LOAD  = 2'b10;
  localparam logic [1:0] CTL_STORE = 2'b11;

  logic [31:0] mem [2**ADDR_W];

  ex_mem_t            req;
  mem_wb_t            out_d, out_q;
  logic [CNT_W-1:0]   ld_cnt_d, ld_cnt_q, st_cnt_d, st_cnt_q;
  logic               fault_d, fault_q;
  logic [31:0]        faddr_d, faddr_q;
  logic [ADDR_W-1:0]  idx;
  logic               aligned;
  logic               mem_we;

  assign req     = ex_mem_t'(ex_mem_bundle_in);
  assign idx     = req.alu[ADDR_W+1:2];
  assign aligned = (req.alu[1:0] == 2'b00);

  always_comb begin
    out_d    = '0;
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    fault_d  = fault_q;
    faddr_d  = faddr_q;
    mem_we   = 1'b0;
    case (req.ctl)
      CTL_ALU: begin
        out_d.reg_write = 1'b1;
        out_d.alu       = req.alu;
        out_d.rd        = req.rd;
      end
      CTL_LOAD, CTL_STORE: begin
        if (!aligned) begin
          // squashed access; only the first fault address is retained
          if (!fault_q) begin
            fault_d = 1'b1;
            faddr_d = req.alu;
          end
        end else if (req.ctl == CTL_LOAD) begin
          out_d.reg_write  = 1'b1;
          out_d.mem_to_reg = 1'b1;
          out_d.rdata      = mem[idx];
          out_d.alu        = req.alu;
          out_d.rd         = req.rd;
          if (ld_cnt_q != '1) ld_cnt_d = ld_cnt_q + CNT_W'(1);
        end else begin
          mem_we    = 1'b1;
          out_d.alu = req.alu;
          if (st_cnt_q != '1) st_cnt_d = st_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
      fault_q  <= 1'b0;
      faddr_q  <= '0;
    end else begin
      out_q    <= out_d;
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
      fault_q  <= fault_d;
      faddr_q  <= faddr_d;
    end
  end

  // Array has no reset; a store on an edge while reset is held low is dropped.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[idx] <= req.sdata;
  end

  assign mem_wb_bundle_out = out_q;
  assign load_count        = ld_cnt_q;
  assign store_count       = st_cnt_q;
  assign misaligned_fault  = fault_q;
  assign fault_addr        = faddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized checks of mem_stage against a word-array reference model.
module tb_mem_stage;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [70:0]       ex;
  logic [70:0]       out;
  logic [CNT_W-1:0]  ld_cnt, st_cnt;
  logic              fault;
  logic [31:0]       faddr;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [70:0] m_out;
  int          m_ld, m_st;
  logic        m_fault;
  logic [31:0] m_faddr;
  logic [31:0] m_mem [int];

  mem_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ex_mem_bundle_in(ex),
    .mem_wb_bundle_out(out), .load_count(ld_cnt), .store_count(st_cnt),
    .misaligned_fault(fault), .fault_addr(faddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".bundle"}, out, m_out);
    chk({tag, ".ld_cnt"}, 71'(ld_cnt), 71'(m_ld));
    chk({tag, ".st_cnt"}, 71'(st_cnt), 71'(m_st));
    chk({tag, ".fault"},  71'(fault), 71'(m_fault));
    chk({tag, ".faddr"},  71'(faddr), 71'(m_faddr));
  endtask

  task automatic model_reset();
    m_out = '0; m_ld = 0; m_st = 0; m_fault = 1'b0; m_faddr = '0;
  endtask

  // Apply one bundle for one edge, predict from the ISA-level rules, then check.
  task automatic step(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                      input logic [31:0] sd, input logic [4:0] rd);
    int  idx;
    bit  al;
    idx = int'((a / 4) % WORDS);
    al  = (a % 4) == 0;
    ex  = {ctl, a, sd, rd};
    m_out = '0;
    if (ctl == 2'd1) m_out = {1'b1, 1'b0, 32'h0, a, rd};
    else if (ctl[1] && !al) begin
      if (!m_fault) begin m_fault = 1'b1; m_faddr = a; end
    end else if (ctl == 2'd2) begin
      m_out = {1'b1, 1'b1, m_mem[idx], a, rd};
      if (m_ld < MAXC) m_ld++;
    end else if (ctl == 2'd3) begin
      m_mem[idx] = sd;
      m_out = {1'b0, 1'b0, 32'h0, a, 5'd0};
      if (m_st < MAXC) m_st++;
    end
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    ex    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    reset = 1'b1;

    step("bubble", 2'd0, 32'h0, 32'h0, 5'd0);
    step("alu",    2'd1, 32'h0000_1234, 32'h5555_5555, 5'd7);
    step("st10",   2'd3, 32'h0000_0010, 32'hDEAD_BEEF, 5'd3);
    step("ld10",   2'd2, 32'h0000_0010, 32'h0, 5'd9);
    step("stwrap", 2'd3, 32'h0000_0404, 32'hCAFE_F00D, 5'd1);
    step("ldwrap", 2'd2, 32'h0000_0004, 32'h0, 5'd4);
    step("ldr0",   2'd2, 32'h0000_0010, 32'h0, 5'd0);
    step("mis_st", 2'd3, 32'h0000_0013, 32'h1111_1111, 5'd2);
    step("mis_ld", 2'd2, 32'h0000_0022, 32'h0, 5'd5);
    step("ld10b",  2'd2, 32'h0000_0010, 32'h0, 5'd6);
    step("st20",   2'd3, 32'h0000_0020, 32'h1111_2222, 5'd0);

    // Asynchronous reset between edges while a store is presented.
    ex = {2'd3, 32'h0000_0020, 32'h9999_9999, 5'd0};
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk); #1;
    chk_all("rst_hold");
    ex = '0;
    reset = 1'b1;
    step("ld20",   2'd2, 32'h0000_0020, 32'h0, 5'd8);
    for (int i = 0; i < 5; i++) step("sat", 2'd2, 32'h0000_0010, 32'h0, 5'(i + 1));

    // Randomized traffic over a pre-initialized 16-word window with aliased upper bits.
    for (int i = 0; i < 16; i++)
      step("prest", 2'd3, ($urandom & 32'hFFFF_FC00) | 32'(i << 2), $urandom, 5'($urandom));
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | 32'(($urandom % 16) << 2);
      if ($urandom % 10 == 0) a[1:0] = 2'($urandom);
      step("rnd", 2'($urandom), a, $urandom, 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
